// File: rtl/serial_chunk_adder_module.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder_module
//   Multi-cycle WIDTH-bit adder/subtractor. Each clock processes one CHUNK-bit
//   slice, least significant slice first. The slice is a ripple chain of
//   full-adder cells. The carry between slices is held in a register.
//   The operation is a + bx + c0, where bx = sub ? ~b : b and c0 = sub ? ~cin : cin.
//
// Parameters
//   WIDTH     operand/result width
//   CHUNK     bits per cycle; must divide WIDTH (N = WIDTH / CHUNK cycles)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request, accepted only in IDLE or DONE
//   sub       0: a+b+cin, 1: a-b-cin (latched with start)
//   a, b      operands (latched with start)
//   cin       carry-in / borrow-in (latched with start)
//   busy      high while slices are being processed
//   done      one-cycle pulse; sum/cout/overflow valid from this cycle
//   sum       result (fills slice by slice while busy)
//   cout      carry out (add) or borrow out (sub)
//   overflow  two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_chunk_adder_module #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bx_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             sub_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;

    logic             accept_s;
    logic             last_s;
    int               base_s;
    logic [CHUNK-1:0] slice_sum_s;
    logic [CHUNK:0]   ripple_s;

    // One full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Ripple-carry slice over the current chunk, fed by the carry register.
    always_comb begin
        base_s      = int'(cnt_r) * CHUNK;
        ripple_s    = {(CHUNK + 1){1'b0}};
        slice_sum_s = {CHUNK{1'b0}};
        ripple_s[0] = carry_r;
        for (int i = 0; i < CHUNK; i++) begin
            {ripple_s[i+1], slice_sum_s[i]} = full_add(a_r[base_s + i], bx_r[base_s + i], ripple_s[i]);
        end
    end

    assign last_s   = (cnt_r == CW'(N - 1));
    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Next-state decode.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_BUSY;
                else       next_state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) next_state_s = ST_DONE;
                else        next_state_s = ST_BUSY;
            end
            ST_DONE: begin
                if (start) next_state_s = ST_BUSY;
                else       next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, operand latches, slice accumulation and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            bx_r    <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_BUSY);
            done_r  <= (next_state_s == ST_DONE);
            if (accept_s) begin
                // Subtraction is a + ~b + ~cin, so fold the inversion in once here.
                a_r     <= a;
                bx_r    <= sub ? ~b : b;
                carry_r <= sub ? ~cin : cin;
                sub_r   <= sub;
                cnt_r   <= {CW{1'b0}};
                sum_r   <= {WIDTH{1'b0}};
            end else if (state_r == ST_BUSY) begin
                sum_r[base_s +: CHUNK] <= slice_sum_s;
                carry_r                <= ripple_s[CHUNK];
                if (last_s) begin
                    // The MSB lives in the last slice, so flags are final on this edge.
                    cnt_r  <= {CW{1'b0}};
                    cout_r <= sub_r ? ~ripple_s[CHUNK] : ripple_s[CHUNK];
                    ovf_r  <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) &&
                              (slice_sum_s[CHUNK-1] != a_r[WIDTH-1]);
                end else begin
                    cnt_r  <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_chunk_adder_module.sv
// ---------------------------------------------------------------------------
// Bench for serial_chunk_adder_module at WIDTH=8.
// Three instances share their inputs: CHUNK=4 (N=2) is the main one, and
// CHUNK=1 (N=8) and CHUNK=8 (N=1) cover the bit-serial and single-cycle ends.
// ---------------------------------------------------------------------------
module tb_serial_chunk_adder_module;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, sub, cin;
    logic [W-1:0] a, b;

    logic         busy4, done4, cout4, ovf4;
    logic [W-1:0] sum4;
    logic         busy1, done1, cout1, ovf1;
    logic [W-1:0] sum1;
    logic         busy8, done8, cout8, ovf8;
    logic [W-1:0] sum8;

    always #5 clk = ~clk;

    serial_chunk_adder_module #(.WIDTH(W), .CHUNK(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
    serial_chunk_adder_module #(.WIDTH(W), .CHUNK(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
    serial_chunk_adder_module #(.WIDTH(W), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Index 0: CHUNK=4, 1: CHUNK=1, 2: CHUNK=8
    logic [W-1:0] r_sum [3];
    logic         r_cout[3];
    logic         r_ovf [3];
    int           r_cyc [3];
    int           r_cnt [3];
    int           busy_cycles4;

    // Issues one operation and watches all instances for a fixed 12-cycle window.
    task automatic run_op(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ci);
        @(negedge clk);
        sub = s; a = aa; b = bb; cin = ci; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_cnt[i] = 0; r_cyc[i] = 0; r_sum[i] = '0; r_cout[i] = 1'b0; r_ovf[i] = 1'b0;
        end
        busy_cycles4 = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (busy4) busy_cycles4++;
            if (done4) begin r_cnt[0]++; r_cyc[0] = k; r_sum[0] = sum4; r_cout[0] = cout4; r_ovf[0] = ovf4; end
            if (done1) begin r_cnt[1]++; r_cyc[1] = k; r_sum[1] = sum1; r_cout[1] = cout1; r_ovf[1] = ovf1; end
            if (done8) begin r_cnt[2]++; r_cyc[2] = k; r_sum[2] = sum8; r_cout[2] = cout8; r_ovf[2] = ovf8; end
            if (k < 12) @(negedge clk);
        end
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         ci;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[10];
    int   exp_cyc[3];

    initial begin
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   t;
        logic [W-1:0] m_sum;
        logic         m_cout, m_ovf, rs, rci;
        logic [W-1:0] ra, rb;
        int           dcount;

        // sub, a, b, cin -> sum, cout/borrow, overflow
        vecs[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h3C, 8'h45, 1'b1, 8'h82, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        exp_cyc[0] = 3; exp_cyc[1] = 9; exp_cyc[2] = 2;

        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy4, done4, sum4, cout4, ovf4}, 32'h0);
        reset = 1'b0;

        // Directed table, all three chunk sizes.
        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].s, vecs[v].va, vecs[v].vb, vecs[v].ci);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("v%0d_i%0d_sum", v, i),   r_sum[i],  vecs[v].e_sum);
                check($sformatf("v%0d_i%0d_cout", v, i),  r_cout[i], vecs[v].e_cout);
                check($sformatf("v%0d_i%0d_ovf", v, i),   r_ovf[i],  vecs[v].e_ovf);
                check($sformatf("v%0d_i%0d_cycle", v, i), r_cyc[i],  exp_cyc[i]);
                check($sformatf("v%0d_i%0d_pulses", v, i), r_cnt[i], 1);
            end
            check($sformatf("v%0d_busy_cycles", v), busy_cycles4, 2);
            check($sformatf("v%0d_hold_sum", v), sum4, vecs[v].e_sum);
        end

        // Back-to-back start in DONE; start pulse and operand changes while busy.
        @(negedge clk);
        sub = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        check("b2b_first_done", done4, 1'b1);
        check("b2b_first_sum", sum4, 8'h46);
        check("b2b_first_cout", cout4, 1'b0);
        sub = 1'b1; a = 8'h50; b = 8'h30; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hC3; b = 8'h3C; sub = 1'b0;
        check("b2b_busy", {busy4, done4}, 2'b10);
        @(negedge clk);
        check("b2b_no_early_done", done4, 1'b0);
        @(negedge clk);
        check("b2b_second_done", done4, 1'b1);
        check("b2b_second_sum", sum4, 8'h20);
        check("b2b_second_flags", {cout4, ovf4}, 2'b00);
        @(negedge clk);
        check("b2b_done_one_cycle", {busy4, done4}, 2'b00);
        repeat (12) @(negedge clk);

        // Reset during the first busy cycle aborts with no done pulse.
        sub = 1'b0; a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", busy4, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs_zero", {busy4, done4, sum4, cout4, ovf4}, 32'h0);
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4 || done1 || done8) dcount++;
        end
        check("abort_no_done", dcount, 0);

        // Pseudo-random operations against an arithmetic reference.
        for (int n = 0; n < 30; n++) begin
            rs  = 1'($urandom_range(1, 0));
            rci = 1'($urandom_range(1, 0));
            ra  = 8'($urandom_range(255, 0));
            rb  = 8'($urandom_range(255, 0));
            bx  = rs ? ~rb : rb;
            c0  = rs ? ~rci : rci;
            t   = {1'b0, ra} + {1'b0, bx} + {{W{1'b0}}, c0};
            m_sum  = t[W-1:0];
            m_cout = rs ? ~t[W] : t[W];
            m_ovf  = (ra[W-1] == bx[W-1]) && (t[W-1] != ra[W-1]);
            run_op(rs, ra, rb, rci);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rnd%0d_i%0d_result", n, i),
                      {r_cnt[i][7:0], r_ovf[i], r_cout[i], r_sum[i]},
                      {8'd1, m_ovf, m_cout, m_sum});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
